seg_scan_capture: RTL and testbench



---
 rtl/seg_scan_capture.sv | 139 +++++++++++++
 tb/tb_seg_scan_capture.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_capture.sv
// seg_scan_capture
//   Receive-side counterpart of the 7-segment digit decoder. It samples the
//   time-multiplexed segment/anode bus that drives the display and rebuilds
//   the BCD code shown at each position. A position is committed only after
//   its {seg, an} pair has been held stable for STABLE_CYCLES registered
//   samples. Once every position has committed, the whole frame is delivered
//   on digits together with a one-cycle frame_valid strobe.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   seg[6:0]     segment pattern, active-high, bit6=a .. bit0=g
//   an[N-1:0]    anode select, active-high, one-hot when a position is lit
//   digits       captured codes, position i at [4i+3:4i]
//                (4'hF = blank, 4'hE = undecodable pattern)
//   frame_valid  one-cycle strobe: digits just updated with a full frame
//   pattern_err  the last delivered frame holds at least one 4'hE code
module seg_scan_capture #(
    parameter int NUM_DIGITS    = 8,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   an,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    frame_valid,
    output logic                    pattern_err
);

    localparam logic [CNT_W-1:0] CntMax    = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CntCommit = CNT_W'(STABLE_CYCLES - 1);

    // Input sample registers
    logic [6:0]              seg_q;
    logic [NUM_DIGITS-1:0]   an_q;

    // Stability tracking
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    committed_q, committed_d;

    // Frame assembly and delivered outputs
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic [4*NUM_DIGITS-1:0] digits_q;
    logic                    frame_valid_q;
    logic                    pattern_err_q;

    logic                    an_onehot;
    logic                    stable;
    logic                    commit;
    logic                    complete;
    logic                    err_d;
    logic [3:0]              code;

    // Decode the registered segment pattern
    always_comb begin
        case (seg_q)
            7'b1111110: code = 4'h0;
            7'b0110000: code = 4'h1;
            7'b1101101: code = 4'h2;
            7'b1111001: code = 4'h3;
            7'b0110011: code = 4'h4;
            7'b1011011: code = 4'h5;
            7'b1011111: code = 4'h6;
            7'b1110000: code = 4'h7;
            7'b1111111: code = 4'h8;
            7'b1111011: code = 4'h9;
            7'b0000000: code = 4'hF;
            default:    code = 4'hE;
        endcase
    end

    always_comb begin
        // Zero or multi-hot anodes are a blanking gap and never count as stable
        an_onehot = (an_q != '0) && ((an_q & (an_q - NUM_DIGITS'(1))) == '0);
        stable    = an_onehot && (seg == seg_q) && (an == an_q);

        // One commit per stable run: committed stays set until the run breaks
        commit    = stable && (cnt_q == CntCommit) && !committed_q;

        cnt_d       = '0;
        committed_d = 1'b0;
        if (stable) begin
            cnt_d       = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);
            committed_d = committed_q | commit;
        end

        // an_q is one-hot on a commit, so it directly selects the shadow slot
        shadow_d = shadow_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (commit && an_q[i]) begin
                shadow_d[4*i +: 4] = code;
            end
        end

        seen_d   = commit ? (seen_q | an_q) : seen_q;
        complete = commit && (&seen_d);

        err_d = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (shadow_d[4*i +: 4] == 4'hE) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q         <= '0;
            an_q          <= '0;
            cnt_q         <= '0;
            committed_q   <= 1'b0;
            shadow_q      <= '1;
            seen_q        <= '0;
            digits_q      <= '1;
            frame_valid_q <= 1'b0;
            pattern_err_q <= 1'b0;
        end else begin
            seg_q         <= seg;
            an_q          <= an;
            cnt_q         <= cnt_d;
            committed_q   <= committed_d;
            shadow_q      <= shadow_d;
            seen_q        <= complete ? '0 : seen_d;
            frame_valid_q <= complete;
            if (complete) begin
                digits_q      <= shadow_d;
                pattern_err_q <= err_d;
            end
        end
    end

    assign digits      = digits_q;
    assign frame_valid = frame_valid_q;
    assign pattern_err = pattern_err_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture. A frame-level model (run lengths of
// identical input pairs, per-position shadow array) predicts the outputs and
// is compared on every falling edge; literal checks pin the key results.
module tb_seg_scan_capture;

    localparam int N = 8;
    localparam int S = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [6:0]     seg = '0;
    logic [N-1:0]   an = '0;
    logic [4*N-1:0] digits;
    logic           frame_valid;
    logic           pattern_err;

    seg_scan_capture #(
        .NUM_DIGITS   (N),
        .STABLE_CYCLES(S)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg        (seg),
        .an         (an),
        .digits     (digits),
        .frame_valid(frame_valid),
        .pattern_err(pattern_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int frames   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Display patterns; 4'hE selects a deliberately undecodable pattern
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'h0: return 7'b1111110;
            4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;
            4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;
            4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;
            4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1111011;
            4'hF: return 7'b0000000;
            default: return 7'b1010101;
        endcase
    endfunction

    function automatic logic [3:0] decode(input logic [6:0] s);
        for (int d = 0; d < 10; d++) begin
            if (seg_of(4'(d)) == s) return 4'(d);
        end
        if (s == 7'b0000000) return 4'hF;
        return 4'hE;
    endfunction

    // ---------------- model ----------------
    logic [4*N-1:0] m_digits;
    logic           m_fv;
    logic           m_err;
    logic [3:0]     m_shadow [N];
    logic [N-1:0]   m_seen;
    logic [6+N:0]   m_prev;
    int             m_run;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_digits = '1;
            m_fv     = 1'b0;
            m_err    = 1'b0;
            for (int i = 0; i < N; i++) m_shadow[i] = 4'hF;
            m_seen   = '0;
            m_prev   = '0;
            m_run    = 0;
        end else begin
            m_fv = 1'b0;
            // run = number of consecutive edges that saw this same lit pair
            if ($countones(an) == 1 && {seg, an} == m_prev) m_run++;
            else m_run = ($countones(an) == 1) ? 1 : 0;
            m_prev = {seg, an};
            // S matching follow-on samples after the first one -> commit once
            if (m_run == S + 1) begin
                for (int i = 0; i < N; i++) begin
                    if (an[i]) begin
                        m_shadow[i] = decode(seg);
                        m_seen[i]   = 1'b1;
                    end
                end
                if (&m_seen) begin
                    m_err = 1'b0;
                    for (int i = 0; i < N; i++) begin
                        m_digits[4*i +: 4] = m_shadow[i];
                        if (m_shadow[i] == 4'hE) m_err = 1'b1;
                    end
                    m_fv   = 1'b1;
                    m_seen = '0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("digits", 64'(digits), 64'(m_digits));
        check("frame_valid", 64'(frame_valid), 64'(m_fv));
        check("pattern_err", 64'(pattern_err), 64'(m_err));
        if (frame_valid) frames++;
    end

    // ---------------- stimulus ----------------
    task automatic hold_in(input logic [6:0] s, input logic [N-1:0] a, input int n);
        seg = s;
        an  = a;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic scan_pos(input int pos, input logic [3:0] d, input int hold);
        hold_in(seg_of(d), N'(1) << pos, hold);
        hold_in(7'b0000000, '0, 2);
    endtask

    task automatic scan_frame(input logic [4*N-1:0] vals);
        for (int p = 0; p < N; p++) scan_pos(p, vals[4*p +: 4], 6);
    endtask

    int f0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_digits", 64'(digits), 64'hFFFF_FFFF);
        check("reset_fv", 64'(frame_valid), 64'h0);
        check("reset_err", 64'(pattern_err), 64'h0);
        rst_n = 1'b1;
        hold_in(7'b0000000, '0, 2);

        // Clean frame 0..7
        f0 = frames;
        scan_frame(32'h7654_3210);
        check("t1_frames", 64'(frames - f0), 64'd1);
        check("t1_digits", 64'(digits), 64'h7654_3210);
        check("t1_err", 64'(pattern_err), 64'h0);

        // Position 3 held too briefly, then rescanned
        f0 = frames;
        for (int p = 0; p < N; p++) scan_pos(p, 4'(9 - p), (p == 3) ? 3 : 6);
        check("t2_no_frame", 64'(frames - f0), 64'd0);
        check("t2_digits_held", 64'(digits), 64'h7654_3210);
        scan_pos(3, 4'h6, 6);
        check("t2_frames", 64'(frames - f0), 64'd1);
        check("t2_digits", 64'(digits), 64'h2345_6789);

        // Two-hot anodes never commit: positions 1..7 alone must not finish a frame
        f0 = frames;
        hold_in(7'b0110000, N'(3), 10);
        hold_in(7'b0000000, '0, 2);
        for (int p = 1; p < N; p++) scan_pos(p, 4'h1, 6);
        check("t4_no_frame", 64'(frames - f0), 64'd0);
        scan_pos(0, 4'h5, 6);
        check("t4_frames", 64'(frames - f0), 64'd1);
        check("t4_digits", 64'(digits), 64'h1111_1115);

        // All blank
        f0 = frames;
        scan_frame(32'hFFFF_FFFF);
        check("t5_frames", 64'(frames - f0), 64'd1);
        check("t5_digits", 64'(digits), 64'hFFFF_FFFF);
        check("t5_err", 64'(pattern_err), 64'h0);

        // Undecodable pattern at position 5, then a clean frame
        scan_frame(32'h76E4_3210);
        check("t3_digits", 64'(digits), 64'h76E4_3210);
        check("t3_err", 64'(pattern_err), 64'h1);
        scan_frame(32'h0123_4567);
        check("t3_clean_digits", 64'(digits), 64'h0123_4567);
        check("t3_clean_err", 64'(pattern_err), 64'h0);

        // Reset mid-frame after 5 commits (with pattern_err set beforehand)
        scan_frame(32'hE000_0000);
        check("t6_err_set", 64'(pattern_err), 64'h1);
        for (int p = 0; p < 5; p++) scan_pos(p, 4'h1, 6);
        rst_n = 1'b0;
        #3;
        check("t6_rst_digits", 64'(digits), 64'hFFFF_FFFF);
        check("t6_rst_err", 64'(pattern_err), 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        f0 = frames;
        hold_in(7'b0000000, '0, 3);
        check("t6_no_release_frame", 64'(frames - f0), 64'd0);
        scan_frame(32'h9999_9999);
        check("t6_frames", 64'(frames - f0), 64'd1);
        check("t6_digits", 64'(digits), 64'h9999_9999);
        check("t6_err", 64'(pattern_err), 64'h0);

        hold_in(7'b0000000, '0, 3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
